// File: rtl/exe_stage_unit_pkg.sv
// Shared constants and helpers for the execute stage: ALU commands, shift types,
// forwarding selects.
package exe_stage_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 4;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] v, input logic [4:0] n);
        return (n == 5'd0) ? v : ((v >> n) | (v << (6'd32 - {1'b0, n})));
    endfunction

    // The reserved select 11 falls back to the ID/EX value.
    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] idex_val,
                                                  input logic [DATA_W-1:0] mem_val,
                                                  input logic [DATA_W-1:0] wb_val);
        case (sel)
            FWD_MEM: return mem_val;
            FWD_WB:  return wb_val;
            default: return idex_val;
        endcase
    endfunction

endpackage

// File: rtl/exe_stage_unit_val2_gen.sv
// Second-operand generator: rotated immediate, memory offset, or immediate-shifted register.
module val2_gen
    import exe_stage_unit_pkg::*;
(
    input  logic [DATA_W-1:0] m,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic              mem_en,
    output logic [DATA_W-1:0] val2
);

    logic [4:0] shamt;

    always_comb begin
        shamt = shift_operand[11:7];
        val2  = m;
        if (imm) begin
            val2 = ror32(DATA_W'(shift_operand[7:0]), {shift_operand[11:8], 1'b0});
        end else if (mem_en) begin
            val2 = DATA_W'(shift_operand);
        end else if (shamt != 5'd0) begin
            case (shift_operand[6:5])
                LSL:     val2 = m << shamt;
                LSR:     val2 = m >> shamt;
                ASR:     val2 = DATA_W'($signed(m) >>> shamt);
                default: val2 = ror32(m, shamt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: operand forwarding, ALU with NZCV flags, branch target,
// and the EX/MEM pipeline register.
module exe_stage_unit
    import exe_stage_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] st_val,
    output logic [REG_W-1:0]  dest
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_m;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] result;
    logic [DATA_W:0]   sum;
    logic              is_sub;
    logic              cin;
    logic              c_new;
    logic              v_new;
    logic              mem_en;

    assign op_a   = fwd_mux(sel_src1, val_rn_in, mem_fwd_val, wb_fwd_val);
    assign op_m   = fwd_mux(sel_src2, val_rm_in, mem_fwd_val, wb_fwd_val);
    assign mem_en = mem_r_en_in | mem_w_en_in;

    val2_gen u_val2_gen (
        .m             (op_m),
        .imm           (imm_in),
        .shift_operand (shift_operand_in),
        .mem_en        (mem_en),
        .val2          (val2)
    );

    // Shared 33-bit adder; subtraction is A + ~val2 + cin so carry out is NOT borrow.
    always_comb begin
        is_sub = (exe_cmd_in == EXE_SUB) || (exe_cmd_in == EXE_SBC);
        cin    = 1'b0;
        case (exe_cmd_in)
            EXE_ADC, EXE_SBC: cin = status[1];
            EXE_SUB:          cin = 1'b1;
            default:          cin = 1'b0;
        endcase
        sum = {1'b0, op_a} + {1'b0, (is_sub ? ~val2 : val2)} + {{DATA_W{1'b0}}, cin};
    end

    always_comb begin
        result = '0;
        c_new  = status[1];
        v_new  = status[0];
        case (exe_cmd_in)
            EXE_MOV: result = val2;
            EXE_MVN: result = ~val2;
            EXE_AND: result = op_a & val2;
            EXE_ORR: result = op_a | val2;
            EXE_EOR: result = op_a ^ val2;
            EXE_ADD, EXE_ADC: begin
                result = sum[DATA_W-1:0];
                c_new  = sum[DATA_W];
                v_new  = (op_a[31] == val2[31]) && (result[31] != op_a[31]);
            end
            EXE_SUB, EXE_SBC: begin
                result = sum[DATA_W-1:0];
                c_new  = sum[DATA_W];
                v_new  = (op_a[31] != val2[31]) && (result[31] != op_a[31]);
            end
            default: result = '0;
        endcase
    end

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

    // EX/MEM register; dest resets to 4'hF so no hazard or forward can match it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            alu_res  <= '0;
            st_val   <= '0;
            dest     <= 4'hF;
            status   <= 4'b0000;
        end else if (!freeze) begin
            wb_en    <= wb_en_in;
            mem_r_en <= mem_r_en_in;
            mem_w_en <= mem_w_en_in;
            alu_res  <= result;
            st_val   <= op_m;
            dest     <= dest_in;
            if (s_in) begin
                status <= {result[31], (result == '0), c_new, v_new};
            end
        end
    end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed self-checking bench for exe_stage_unit with hand-computed expectations.
module tb_exe_stage_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] val_rn_in, val_rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
    logic [31:0] pc_in;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res, st_val;
    logic [3:0]  dest;

    int n_checks = 0;
    int n_fail   = 0;

    exe_stage_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .pc_in(pc_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .st_val(st_val), .dest(dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; freeze = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; b_in = 1'b0; s_in = 1'b0;
        exe_cmd_in = 4'b0000; val_rn_in = '0; val_rm_in = '0; imm_in = 1'b0;
        shift_operand_in = '0; signed_imm_24_in = '0; dest_in = 4'h0; pc_in = '0;
        sel_src1 = 2'b00; sel_src2 = 2'b00; mem_fwd_val = '0; wb_fwd_val = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1; dest_in = 4'h3;
        step();
        n_checks++; if (alu_res !== 32'h0) begin n_fail++; $display("FAIL reset_alu_res: got %h expected %h", alu_res, 32'h0); end
        n_checks++; if (dest !== 4'hF) begin n_fail++; $display("FAIL reset_dest: got %h expected %h", dest, 4'hF); end
        n_checks++; if (status !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b expected %b", status, 4'b0000); end
        n_checks++; if ({wb_en, mem_r_en, mem_w_en} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", {wb_en, mem_r_en, mem_w_en}, 3'b000); end
        clear_inputs();
    endtask

    task automatic test_add_overflow();
        clear_inputs();
        exe_cmd_in = 4'b0010; s_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'h3;
        val_rn_in = 32'h7FFF_FFFF; imm_in = 1'b1; shift_operand_in = 12'h001;
        step();
        n_checks++; if (alu_res !== 32'h8000_0000) begin n_fail++; $display("FAIL add_ovf_res: got %h expected %h", alu_res, 32'h8000_0000); end
        n_checks++; if (status !== 4'b1001) begin n_fail++; $display("FAIL add_ovf_status: got %b expected %b", status, 4'b1001); end
        n_checks++; if (dest !== 4'h3 || wb_en !== 1'b1) begin n_fail++; $display("FAIL add_ovf_dest_wb: got %h/%b expected 3/1", dest, wb_en); end
    endtask

    task automatic test_sub_and();
        clear_inputs();
        exe_cmd_in = 4'b0100; s_in = 1'b1; val_rn_in = 32'd5; val_rm_in = 32'd5;
        step();
        n_checks++; if (alu_res !== 32'h0) begin n_fail++; $display("FAIL sub_res: got %h expected %h", alu_res, 32'h0); end
        n_checks++; if (status !== 4'b0110) begin n_fail++; $display("FAIL sub_status: got %b expected %b", status, 4'b0110); end
        exe_cmd_in = 4'b0110; val_rn_in = 32'h1F; val_rm_in = 32'h10;
        step();
        n_checks++; if (alu_res !== 32'h10) begin n_fail++; $display("FAIL and_res: got %h expected %h", alu_res, 32'h10); end
        n_checks++; if (status !== 4'b0010) begin n_fail++; $display("FAIL and_status: got %b expected %b", status, 4'b0010); end
    endtask

    // Status is 0010 on entry (C=1); all ops here leave s=0.
    task automatic test_val2_and_alu();
        clear_inputs();
        exe_cmd_in = 4'b0001; imm_in = 1'b1; shift_operand_in = 12'h4FF;
        step();
        n_checks++; if (alu_res !== 32'hFF00_0000) begin n_fail++; $display("FAIL mov_imm_rot: got %h expected %h", alu_res, 32'hFF00_0000); end
        imm_in = 1'b0; val_rm_in = 32'h8000_0000; shift_operand_in = 12'h0C0;
        step();
        n_checks++; if (alu_res !== 32'hC000_0000) begin n_fail++; $display("FAIL mov_asr1: got %h expected %h", alu_res, 32'hC000_0000); end
        val_rm_in = 32'h0000_000F; shift_operand_in = 12'h260;
        step();
        n_checks++; if (alu_res !== 32'hF000_0000) begin n_fail++; $display("FAIL mov_ror4: got %h expected %h", alu_res, 32'hF000_0000); end
        val_rm_in = 32'h0000_0080; shift_operand_in = 12'h220;
        step();
        n_checks++; if (alu_res !== 32'h0000_0008) begin n_fail++; $display("FAIL mov_lsr4: got %h expected %h", alu_res, 32'h8); end
        val_rm_in = 32'h8000_0001; shift_operand_in = 12'h040;
        step();
        n_checks++; if (alu_res !== 32'h8000_0001) begin n_fail++; $display("FAIL mov_asr0_pass: got %h expected %h", alu_res, 32'h8000_0001); end
        exe_cmd_in = 4'b0011; val_rn_in = 32'd1; imm_in = 1'b1; shift_operand_in = 12'h002;
        step();
        n_checks++; if (alu_res !== 32'd4) begin n_fail++; $display("FAIL adc_res: got %h expected %h", alu_res, 32'd4); end
        exe_cmd_in = 4'b0101; val_rn_in = 32'd10; shift_operand_in = 12'h003;
        step();
        n_checks++; if (alu_res !== 32'd7) begin n_fail++; $display("FAIL sbc_res: got %h expected %h", alu_res, 32'd7); end
        exe_cmd_in = 4'b1001; shift_operand_in = 12'h000;
        step();
        n_checks++; if (alu_res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mvn_res: got %h expected %h", alu_res, 32'hFFFF_FFFF); end
        exe_cmd_in = 4'b1000; val_rn_in = 32'hF0F0_F0F0; shift_operand_in = 12'h0FF;
        step();
        n_checks++; if (alu_res !== 32'hF0F0_F00F) begin n_fail++; $display("FAIL eor_res: got %h expected %h", alu_res, 32'hF0F0_F00F); end
        exe_cmd_in = 4'b1111;
        step();
        n_checks++; if (alu_res !== 32'h0) begin n_fail++; $display("FAIL undef_cmd_res: got %h expected %h", alu_res, 32'h0); end
        n_checks++; if (status !== 4'b0010) begin n_fail++; $display("FAIL s0_status_hold: got %b expected %b", status, 4'b0010); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        exe_cmd_in = 4'b0010; val_rn_in = 32'hDEAD; val_rm_in = 32'hBEEF;
        sel_src1 = 2'b01; mem_fwd_val = 32'h10; sel_src2 = 2'b10; wb_fwd_val = 32'h20;
        step();
        n_checks++; if (alu_res !== 32'h30) begin n_fail++; $display("FAIL fwd_add: got %h expected %h", alu_res, 32'h30); end
        sel_src1 = 2'b00; val_rn_in = 32'h1000; mem_w_en_in = 1'b1; shift_operand_in = 12'h004;
        step();
        n_checks++; if (st_val !== 32'h20) begin n_fail++; $display("FAIL str_st_val: got %h expected %h", st_val, 32'h20); end
        n_checks++; if (alu_res !== 32'h1004) begin n_fail++; $display("FAIL str_addr: got %h expected %h", alu_res, 32'h1004); end
        n_checks++; if (mem_w_en !== 1'b1) begin n_fail++; $display("FAIL str_mem_w_en: got %b expected %b", mem_w_en, 1'b1); end
        mem_w_en_in = 1'b0; sel_src1 = 2'b11; val_rn_in = 32'd7; imm_in = 1'b1; shift_operand_in = 12'h001;
        step();
        n_checks++; if (alu_res !== 32'd8) begin n_fail++; $display("FAIL fwd_reserved_sel: got %h expected %h", alu_res, 32'd8); end
    endtask

    task automatic test_branch();
        clear_inputs();
        b_in = 1'b1; pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
        #1;
        n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL branch_taken: got %b expected %b", branch_taken, 1'b1); end
        n_checks++; if (branch_addr !== 32'hF8) begin n_fail++; $display("FAIL branch_back: got %h expected %h", branch_addr, 32'hF8); end
        pc_in = 32'h0; signed_imm_24_in = 24'h000004;
        #1;
        n_checks++; if (branch_addr !== 32'h10) begin n_fail++; $display("FAIL branch_fwd: got %h expected %h", branch_addr, 32'h10); end
        b_in = 1'b0;
        #1;
        n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken: got %b expected %b", branch_taken, 1'b0); end
    endtask

    task automatic test_freeze_reset();
        clear_inputs();
        exe_cmd_in = 4'b0010; s_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'h5;
        val_rn_in = 32'd1; imm_in = 1'b1; shift_operand_in = 12'h001;
        step();
        n_checks++; if (alu_res !== 32'd2 || status !== 4'b0000) begin n_fail++; $display("FAIL pre_freeze: got %h/%b expected 2/0000", alu_res, status); end
        freeze = 1'b1; val_rn_in = 32'h7FFF_FFFF; dest_in = 4'h9; wb_en_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (alu_res !== 32'd2 || status !== 4'b0000 || dest !== 4'h5 || wb_en !== 1'b1) begin
                n_fail++; $display("FAIL freeze_hold[%0d]: got %h/%b/%h/%b expected 2/0000/5/1", i, alu_res, status, dest, wb_en);
            end
        end
        rst = 1'b1;
        step();
        n_checks++; if (alu_res !== 32'h0 || dest !== 4'hF || status !== 4'b0000 || wb_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_over_freeze: got %h/%h/%b/%b expected 0/f/0000/0", alu_res, dest, status, wb_en);
        end
    endtask

    task automatic test_bubble();
        clear_inputs();
        exe_cmd_in = 4'b0100; s_in = 1'b1; wb_en_in = 1'b1; val_rn_in = 32'd5; val_rm_in = 32'd5; dest_in = 4'h2;
        step();
        n_checks++; if (status !== 4'b0110) begin n_fail++; $display("FAIL bubble_setup_status: got %b expected %b", status, 4'b0110); end
        clear_inputs();
        step();
        n_checks++; if ({wb_en, mem_r_en, mem_w_en} !== 3'b000) begin n_fail++; $display("FAIL bubble_ctrl: got %b expected %b", {wb_en, mem_r_en, mem_w_en}, 3'b000); end
        n_checks++; if (status !== 4'b0110) begin n_fail++; $display("FAIL bubble_status: got %b expected %b", status, 4'b0110); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_add_overflow();
        test_sub_and();
        test_val2_and_alu();
        test_forwarding();
        test_branch();
        test_freeze_reset();
        test_bubble();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
